// File: rtl/fifo_bus_pkg.sv
// fifo_bus_pkg: shared state encoding, ID width and header decode for the bus router
package fifo_bus_pkg;
  typedef enum logic [1:0] {IDLE, POP, SEND, DONE} state_e;
  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BC_ID = 8'hFF;
  function automatic logic [ID_W-1:0] pkt_id(input logic [63:0] pkt, input int sh);
    return ID_W'(pkt >> sh);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req bit after ptr, with wrap
// ports: req (N requests), ptr (last winner), gnt_idx (winner index), any_req (some request set)
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any_req
);
  logic [IW-1:0] j;
  always_comb begin
    gnt_idx = '0;
    j = '0;
    any_req = |req;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % N);
      gnt_idx = req[j] ? j : gnt_idx;
    end
  end
endmodule

// File: rtl/fifo_bus_router.sv
// fifo_bus_router: pops one packet at a time from the device TX FIFOs and routes it to the RX FIFOs
// ports: pndng/D_pop/pop (TX side), full/push/D_push (RX side), err (invalid-ID drop pulse), busy
module fifo_bus_router
  import fifo_bus_pkg::*;
#(
  parameter int pckg_sz = 16,
  parameter int drvrs = 4,
  parameter logic [ID_W-1:0] bc_id = BC_ID,
  localparam int IW = drvrs > 1 ? $clog2(drvrs) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  input  logic [drvrs-1:0]           full,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic                       err,
  output logic                       busy
);
  state_e state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, grant_q, grant_d, gnt;
  logic [pckg_sz-1:0] pkt_q, pkt_d, dpush_q, dpush_d;
  logic [drvrs-1:0] pop_q, pop_d, push_q, push_d, mask;
  logic err_q, err_d, busy_q, busy_d, any_req, uni, valid;
  logic [ID_W-1:0] id;

  rr_arbiter #(.N(drvrs)) u_arb (.req(pndng), .ptr(rr_q), .gnt_idx(gnt), .any_req(any_req));

  // broadcast excludes the sender; with a single device that leaves an empty mask
  always_comb begin
    id = pkt_id(64'(pkt_q), pckg_sz - ID_W);
    uni = 32'(id) < drvrs;
    valid = uni || id == bc_id;
    mask = uni ? drvrs'(1) << id : id == bc_id ? ~(drvrs'(1) << grant_q) : '0;
  end

  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    grant_d = grant_q;
    pkt_d = pkt_q;
    pop_d = '0;
    push_d = '0;
    dpush_d = dpush_q;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (any_req) begin
        grant_d = gnt;
        pkt_d = D_pop[int'(gnt)*pckg_sz +: pckg_sz];
        pop_d = drvrs'(1) << gnt;
        rr_d = gnt;
        state_d = POP;
      end
      POP: state_d = SEND;
      SEND: if (!valid) begin
        err_d = 1'b1;
        state_d = DONE;
      end else if (~|(mask & full)) begin
        push_d = mask;
        dpush_d = pkt_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= IW'(drvrs - 1);
      grant_q <= '0;
      pkt_q <= '0;
      pop_q <= '0;
      push_q <= '0;
      dpush_q <= '0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      grant_q <= grant_d;
      pkt_q <= pkt_d;
      pop_q <= pop_d;
      push_q <= push_d;
      dpush_q <= dpush_d;
      err_q <= err_d;
      busy_q <= busy_d;
    end
  end

  assign pop = pop_q;
  assign push = push_q;
  assign D_push = dpush_q;
  assign err = err_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_fifo_bus_router.sv
// tb_fifo_bus_router: directed self-checking bench for fifo_bus_router
module tb_fifo_bus_router;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] pndng, pop, full, push;
  logic [63:0] D_pop;
  logic [15:0] D_push;
  logic err, busy;
  int n_chk = 0;
  int n_fail = 0;

  fifo_bus_router dut (
    .clk(clk), .rst_n(rst_n), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .full(full), .push(push), .D_push(D_push), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic [15:0] v);
    D_pop[i*16 +: 16] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pndng = '0;
    full = '0;
    D_pop = '0;
    #1;
    chk("rst_pop", 32'(pop), 0);
    chk("rst_push", 32'(push), 0);
    chk("rst_dpush", 32'(D_push), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    step();
    step();
    rst_n = 1'b1;
    // single unicast: device 1 -> device 2
    put(1, 16'h02AB);
    pndng = 4'b0010;
    step();
    chk("uni_pop", 32'(pop), 32'h2);
    chk("uni_busy", 32'(busy), 1);
    pndng = '0;
    step();
    chk("uni_pop_off", 32'(pop), 0);
    chk("uni_push_early", 32'(push), 0);
    step();
    chk("uni_push", 32'(push), 32'h4);
    chk("uni_dpush", 32'(D_push), 32'h02AB);
    step();
    chk("uni_push_off", 32'(push), 0);
    chk("uni_idle", 32'(busy), 0);
    // round-robin from a fresh reset, all packets to device 0
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) put(i, 16'(16'h0010 + i));
    pndng = 4'b1111;
    begin
      int exp_g[5] = '{0, 1, 2, 3, 0};
      for (int n = 0; n < 5; n++) begin
        step();
        chk("rr_grant", 32'(pop), 32'(1) << exp_g[n]);
        step();
        step();
        chk("rr_push", 32'(push), 32'h1);
        chk("rr_dpush", 32'(D_push), 32'h0010 + 32'(exp_g[n]));
        if (n == 4) pndng = '0;
        step();
      end
    end
    // broadcast from device 2
    put(2, 16'hFF55);
    pndng = 4'b0100;
    step();
    chk("bc_pop", 32'(pop), 32'h4);
    pndng = '0;
    step();
    step();
    chk("bc_push", 32'(push), 32'hB);
    chk("bc_dpush", 32'(D_push), 32'hFF55);
    step();
    chk("bc_push_off", 32'(push), 0);
    // backpressure: device 3 to itself while full[3]
    put(3, 16'h0377);
    pndng = 4'b1000;
    full = 4'b1000;
    step();
    chk("bp_pop", 32'(pop), 32'h8);
    pndng = '0;
    step();
    for (int n = 0; n < 10; n++) begin
      step();
      chk("bp_stall_push", 32'(push), 0);
      chk("bp_stall_busy", 32'(busy), 1);
    end
    full = '0;
    step();
    chk("bp_push", 32'(push), 32'h8);
    chk("bp_dpush", 32'(D_push), 32'h0377);
    step();
    chk("bp_push_off", 32'(push), 0);
    chk("bp_idle", 32'(busy), 0);
    // invalid destination from device 0
    put(0, 16'h0712);
    pndng = 4'b0001;
    step();
    chk("inv_pop", 32'(pop), 32'h1);
    pndng = '0;
    step();
    step();
    chk("inv_err", 32'(err), 1);
    chk("inv_push", 32'(push), 0);
    step();
    chk("inv_err_off", 32'(err), 0);
    chk("inv_idle", 32'(busy), 0);
    // reset while stalled in SEND
    put(1, 16'h0011);
    pndng = 4'b0010;
    full = 4'b0001;
    step();
    chk("mid_pop", 32'(pop), 32'h2);
    pndng = '0;
    step();
    step();
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pop", 32'(pop), 0);
    chk("mid_rst_push", 32'(push), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    full = '0;
    for (int i = 0; i < 4; i++) put(i, 16'h0000);
    pndng = 4'b1111;
    #2;
    rst_n = 1'b1;
    step();
    chk("mid_first_grant", 32'(pop), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
